// File: rtl/slot_pkg.sv
// Shared types, constants and BCD helpers for the slot-machine spin datapath.
package slot_pkg;

   localparam int DIGIT_W   = 4;
   localparam int NUM_REELS = 4;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_TWO   = 2'b01;
   localparam logic [1:0] WIN_THREE = 2'b10;
   localparam logic [1:0] WIN_FOUR  = 2'b11;

   localparam logic [DIGIT_W-1:0] STEP_R0 = 4'd1;
   localparam logic [DIGIT_W-1:0] STEP_R1 = 4'd3;
   localparam logic [DIGIT_W-1:0] STEP_R2 = 4'd7;
   localparam logic [DIGIT_W-1:0] STEP_R3 = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SPIN = 2'b01,
      ST_EVAL = 2'b10
   } fsm_state_e;

   function automatic logic [DIGIT_W-1:0] reel_step(input logic [1:0] idx);
      logic [DIGIT_W-1:0] s;
      case (idx)
         2'd0:    s = STEP_R0;
         2'd1:    s = STEP_R1;
         2'd2:    s = STEP_R2;
         2'd3:    s = STEP_R3;
         default: s = STEP_R0;
      endcase
      return s;
   endfunction

   // Folds a raw LFSR nibble 10..15 back into 4..9 so every reel starts on a valid digit.
   function automatic logic [DIGIT_W-1:0] bcd_fold(input logic [DIGIT_W-1:0] d);
      logic [DIGIT_W-1:0] r;
      if (d >= 4'd10) begin
         r = d - 4'd6;
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [DIGIT_W-1:0] bcd_step(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] step);
      logic [DIGIT_W:0] s;
      s = {1'b0, d} + {1'b0, step};
      if (s >= 5'd10) begin
         s = s - 5'd10;
      end else begin
         s = s;
      end
      return s[DIGIT_W-1:0];
   endfunction

endpackage

// File: rtl/slot_match_eval.sv
// Combinational win-level evaluation: largest group of equal digits among four reels.
module slot_match_eval
   import slot_pkg::*;
(
   input  logic [DIGIT_W-1:0] d0,
   input  logic [DIGIT_W-1:0] d1,
   input  logic [DIGIT_W-1:0] d2,
   input  logic [DIGIT_W-1:0] d3,
   output logic [1:0]         win_level
);

   logic e01_s, e02_s, e03_s, e12_s, e13_s, e23_s;
   logic four_s, three_s, pair_s;

   // Pairwise equality, then groups of three and four built from those pairs.
   always_comb begin
      e01_s   = (d0 == d1);
      e02_s   = (d0 == d2);
      e03_s   = (d0 == d3);
      e12_s   = (d1 == d2);
      e13_s   = (d1 == d3);
      e23_s   = (d2 == d3);
      four_s  = e01_s & e12_s & e23_s;
      three_s = (e01_s & e12_s) | (e01_s & e13_s) | (e02_s & e23_s) | (e12_s & e23_s);
      pair_s  = e01_s | e02_s | e03_s | e12_s | e13_s | e23_s;
      if (four_s) begin
         win_level = WIN_FOUR;
      end else if (three_s) begin
         win_level = WIN_THREE;
      end else if (pair_s) begin
         win_level = WIN_TWO;
      end else begin
         win_level = WIN_NONE;
      end
   end

endmodule

// File: rtl/slot_spin_evaluator.sv
// Spin controller: seeds four BCD reels from a free-running LFSR, stops them in turn,
// and presents the win level for exactly one clock per spin.
module slot_spin_evaluator
   import slot_pkg::*;
#(
   parameter int          SPIN_CYCLES = 8,
   parameter int          STOP_GAP    = 4,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spin_req,
   output logic        busy,
   output logic [15:0] reel_digits,
   output logic        result_valid,
   output logic [1:0]  state
);

   localparam int T_LAST  = SPIN_CYCLES + 3 * STOP_GAP;
   localparam int TIMER_W = $clog2(T_LAST + 2);

   fsm_state_e         fsm_q, fsm_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [DIGIT_W-1:0] reel_q [NUM_REELS];
   logic [DIGIT_W-1:0] reel_d [NUM_REELS];
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic [1:0]         win_q, win_d;
   logic [1:0]         win_s;

   // Scored on the next-cycle reel values so the registered level lines up with EVAL.
   slot_match_eval u_match (
      .d0        (reel_d[0]),
      .d1        (reel_d[1]),
      .d2        (reel_d[2]),
      .d3        (reel_d[3]),
      .win_level (win_s)
   );

   // Next-state, reel stepping and LFSR advance.
   always_comb begin
      fsm_d   = fsm_q;
      timer_d = timer_q;
      reel_d  = reel_q;
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      case (fsm_q)
         ST_IDLE: begin
            if (spin_req) begin
               for (int i = 0; i < NUM_REELS; i++) begin
                  reel_d[i] = bcd_fold(lfsr_q[DIGIT_W*i +: DIGIT_W]);
               end
               timer_d = TIMER_W'(1);
               fsm_d   = ST_SPIN;
            end else begin
               timer_d = '0;
            end
         end
         ST_SPIN: begin
            // Reel i keeps stepping up to and including its own stop time, then holds.
            for (int i = 0; i < NUM_REELS; i++) begin
               if (timer_q <= TIMER_W'(SPIN_CYCLES + i * STOP_GAP)) begin
                  reel_d[i] = bcd_step(reel_q[i], reel_step(2'(i)));
               end else begin
                  reel_d[i] = reel_q[i];
               end
            end
            timer_d = timer_q + TIMER_W'(1);
            if (timer_q == TIMER_W'(T_LAST)) begin
               fsm_d = ST_EVAL;
            end else begin
               fsm_d = ST_SPIN;
            end
         end
         ST_EVAL: begin
            fsm_d   = ST_IDLE;
            timer_d = '0;
         end
         default: begin
            fsm_d   = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Output staging: flags derive from the state being entered so they are registered.
   always_comb begin
      busy_d  = (fsm_d != ST_IDLE);
      valid_d = (fsm_d == ST_EVAL);
      if (valid_d) begin
         win_d = win_s;
      end else begin
         win_d = WIN_NONE;
      end
   end

   // State registers; reset discards any spin in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q   <= ST_IDLE;
         lfsr_q  <= LFSR_SEED;
         timer_q <= '0;
         reel_q  <= '{default: '0};
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         win_q   <= WIN_NONE;
      end else begin
         fsm_q   <= fsm_d;
         lfsr_q  <= lfsr_d;
         timer_q <= timer_d;
         reel_q  <= reel_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         win_q   <= win_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign state        = win_q;
   assign reel_digits  = {reel_q[3], reel_q[2], reel_q[1], reel_q[0]};

endmodule

// File: tb/tb_slot_spin_evaluator.sv
// Directed bench for slot_spin_evaluator and slot_match_eval with a cycle reference model.
module tb_slot_spin_evaluator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        spin_req = 1'b0;
   logic        busy;
   logic [15:0] reel_digits;
   logic        result_valid;
   logic [1:0]  state;

   logic [3:0]  md0, md1, md2, md3;
   logic [1:0]  mwin;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_lfsr;
   int          m_st;
   int          m_t;
   logic [3:0]  m_reel [4];
   int          step_tab [4] = '{1, 3, 7, 9};

   always #5 clk = ~clk;

   slot_spin_evaluator dut (
      .clk          (clk),
      .reset        (reset),
      .spin_req     (spin_req),
      .busy         (busy),
      .reel_digits  (reel_digits),
      .result_valid (result_valid),
      .state        (state)
   );

   slot_match_eval u_match (
      .d0        (md0),
      .d1        (md1),
      .d2        (md2),
      .d3        (md3),
      .win_level (mwin)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr = 16'hACE1;
      m_st   = 0;
      m_t    = 0;
      for (int i = 0; i < 4; i++) m_reel[i] = 4'd0;
   endtask

   // One rising edge of the reference: 0 idle, 1 spin, 2 eval.
   task automatic model_step();
      logic [3:0] v;
      if (reset) begin
         case (m_st)
            0: if (spin_req) begin
                  for (int i = 0; i < 4; i++) begin
                     v = m_lfsr[4*i +: 4];
                     m_reel[i] = (v >= 4'd10) ? v - 4'd6 : v;
                  end
                  m_t  = 1;
                  m_st = 1;
               end
            1: begin
                  for (int i = 0; i < 4; i++)
                     if (m_t <= 8 + 4 * i) m_reel[i] = 4'((int'(m_reel[i]) + step_tab[i]) % 10);
                  if (m_t == 20) m_st = 2;
                  m_t++;
               end
            default: begin
                  m_st = 0;
                  m_t  = 0;
               end
         endcase
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
   endtask

   function automatic logic [1:0] model_win();
      int best = 0;
      for (int i = 0; i < 4; i++) begin
         int c = 0;
         for (int j = 0; j < 4; j++) if (m_reel[j] == m_reel[i]) c++;
         if (c > best) best = c;
      end
      return (best == 4) ? 2'b11 : (best == 3) ? 2'b10 : (best == 2) ? 2'b01 : 2'b00;
   endfunction

   task automatic cmp_outputs(input string tag);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (reel_digits[4*i +: 4] > 4'd9) ok = 1'b0;
      chk_eq({tag, ".busy"}, 32'(busy), 32'(m_st != 0));
      chk_eq({tag, ".valid"}, 32'(result_valid), 32'(m_st == 2));
      chk_eq({tag, ".state"}, 32'(state), (m_st == 2) ? 32'(model_win()) : 32'd0);
      chk_eq({tag, ".digits"}, 32'(reel_digits), 32'({m_reel[3], m_reel[2], m_reel[1], m_reel[0]}));
      chk_eq({tag, ".bcd"}, 32'(ok), 32'd1);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp_outputs(tag);
   endtask

   task automatic chk_match(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic [1:0] exp, input string tag);
      md0 = a; md1 = b; md2 = c; md3 = d;
      #1;
      chk_eq(tag, 32'(mwin), 32'(exp));
   endtask

   initial begin
      int busy_cnt, rv_cnt, rv_at, p1, p2;
      model_reset();

      chk_match(4'd7, 4'd7, 4'd7, 4'd7, 2'b11, "match_7777");
      chk_match(4'd3, 4'd3, 4'd5, 4'd3, 2'b10, "match_3353");
      chk_match(4'd1, 4'd2, 4'd1, 4'd2, 2'b01, "match_1212");
      chk_match(4'd9, 4'd9, 4'd0, 4'd4, 2'b01, "match_9904");
      chk_match(4'd0, 4'd1, 4'd2, 4'd3, 2'b00, "match_0123");

      // Spin request while held in reset must be ignored.
      @(negedge clk);
      spin_req = 1'b1;
      tick("rst_req");
      spin_req = 1'b0;
      tick("rst_idle");
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_valid", 32'(result_valid), 32'd0);
      chk_eq("rst_state", 32'(state), 32'd0);
      chk_eq("rst_digits", 32'(reel_digits), 32'd0);

      // First edge after release accepts with lfsr=ACE1: reels {1,E->8,C->6,A->4}.
      spin_req = 1'b1;
      reset    = 1'b1;
      tick("s1_c1");
      chk_eq("s1_load", 32'(reel_digits), 32'h4681);
      spin_req = 1'b0;
      busy_cnt = 1; rv_cnt = 0; rv_at = 0;
      for (int k = 2; k <= 26; k++) begin
         spin_req = (k == 5 || k == 22);
         tick($sformatf("s1_c%0d", k));
         if (busy) busy_cnt++;
         if (result_valid) begin rv_cnt++; rv_at = k; end
         if (k == 21) begin
            chk_eq("s1_final", 32'(reel_digits), 32'h4849);
            chk_eq("s1_win", 32'(state), 32'd1);
         end
      end
      spin_req = 1'b0;
      chk_eq("s1_busy_len", 32'(busy_cnt), 32'd21);
      chk_eq("s1_pulses", 32'(rv_cnt), 32'd1);
      chk_eq("s1_pulse_at", 32'(rv_at), 32'd21);

      // Held request: one idle cycle between result pulse and next acceptance.
      spin_req = 1'b1;
      rv_cnt = 0; p1 = 0; p2 = 0;
      for (int k = 1; k <= 50; k++) begin
         tick($sformatf("hold_c%0d", k));
         if (result_valid) begin
            rv_cnt++;
            if (p1 == 0) p1 = k; else if (p2 == 0) p2 = k;
         end
         if (p1 != 0 && k == p1 + 1) chk_eq("hold_idle", 32'(busy), 32'd0);
         if (p1 != 0 && k == p1 + 2) chk_eq("hold_reaccept", 32'(busy), 32'd1);
      end
      chk_eq("hold_pulses", 32'(rv_cnt), 32'd2);
      chk_eq("hold_first", 32'(p1), 32'd21);
      chk_eq("hold_gap", 32'(p2 - p1), 32'd22);
      spin_req = 1'b0;
      for (int k = 1; k <= 22; k++) tick($sformatf("drain_c%0d", k));

      // Reset at timer 10 clears outputs without a clock edge.
      spin_req = 1'b1;
      tick("mid_c1");
      spin_req = 1'b0;
      for (int k = 2; k <= 10; k++) tick($sformatf("mid_c%0d", k));
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk_eq("mid_busy", 32'(busy), 32'd0);
      chk_eq("mid_valid", 32'(result_valid), 32'd0);
      chk_eq("mid_state", 32'(state), 32'd0);
      chk_eq("mid_digits", 32'(reel_digits), 32'd0);
      @(negedge clk);
      tick("mid_hold");
      reset  = 1'b1;
      rv_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         tick($sformatf("post_c%0d", k));
         if (result_valid) rv_cnt++;
      end
      chk_eq("post_no_result", 32'(rv_cnt), 32'd0);

      spin_req = 1'b1;
      tick("fin_c1");
      spin_req = 1'b0;
      rv_cnt = 0;
      for (int k = 2; k <= 23; k++) begin
         tick($sformatf("fin_c%0d", k));
         if (result_valid) rv_cnt++;
      end
      chk_eq("fin_pulses", 32'(rv_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
